// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: instruction/opcode geometry and fetch FSM states.
package cpu_pkg;

    localparam int INSTR_W    = 32;
    localparam int OPCODE_W   = 6;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;

    localparam logic [OPCODE_W-1:0] OP_NOP = 6'b000000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_t;

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for a fetched word that arrived while decode was stalled.
module fetch_skid_buf
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               unload,
    input  logic               clear,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [31:0]        load_pc,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        pc
);

    // A load in the same cycle as an unload replaces the entry being drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end else if (unload) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register, skid buffer and redirect/discard handling.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                pc_src,
    input  logic [31:0]         branch_target,
    output logic                imem_req,
    output logic [31:0]         imem_addr,
    input  logic                imem_ready,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic                if_id_valid,
    output logic [INSTR_W-1:0]  if_id_instr,
    output logic [31:0]         if_id_pc,
    output logic [OPCODE_W-1:0] opcode,
    output logic [31:0]         perf_fetched,
    output logic [31:0]         perf_stalls
);

    localparam logic [1:0] S_IDLE    = ST_IDLE;
    localparam logic [1:0] S_FETCH   = ST_FETCH;
    localparam logic [1:0] S_DISCARD = ST_DISCARD;

    logic [1:0]         state, state_n;
    logic [31:0]        pc, pc_n;
    logic               req_n;
    logic [31:0]        addr_n;
    logic               skid_valid;
    logic [INSTR_W-1:0] skid_instr;
    logic [31:0]        skid_pc;
    logic               ack, fetch_ok, ifid_accept;
    logic               skid_load, skid_unload, ifid_from_mem, ifid_load, skid_next_valid;

    assign ack         = imem_req & imem_ready;
    assign fetch_ok    = ack & (state == S_FETCH) & ~pc_src;
    assign ifid_accept = ~stall | ~if_id_valid;

    // The skid entry is older than any word returning now, so it always drains first.
    assign skid_unload     = ifid_accept & skid_valid & ~pc_src;
    assign ifid_from_mem   = fetch_ok & ifid_accept & ~skid_valid;
    assign skid_load       = fetch_ok & ~ifid_from_mem;
    assign ifid_load       = skid_unload | ifid_from_mem;
    assign skid_next_valid = (skid_valid & ~skid_unload) | skid_load;

    always_comb begin
        state_n = state;
        pc_n    = pc;
        req_n   = imem_req;
        addr_n  = imem_addr;
        case (state)
            S_IDLE: begin
                state_n = S_FETCH;
                if (pc_src) pc_n = branch_target;
            end
            S_FETCH: begin
                if (imem_req && !imem_ready) begin
                    if (pc_src) begin
                        pc_n    = branch_target;
                        state_n = S_DISCARD;
                    end
                end else if (pc_src) begin
                    pc_n   = branch_target;
                    req_n  = 1'b1;
                    addr_n = branch_target;
                end else begin
                    pc_n  = ack ? pc + 32'd4 : pc;
                    req_n = ~skid_next_valid;
                    if (req_n) addr_n = pc_n;
                end
            end
            S_DISCARD: begin
                // The request in flight still has to complete; its data is thrown away.
                if (pc_src) pc_n = branch_target;
                if (imem_ready) begin
                    state_n = S_FETCH;
                    req_n   = 1'b1;
                    addr_n  = pc_src ? branch_target : pc;
                    pc_n    = addr_n;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            imem_req  <= req_n;
            imem_addr <= addr_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id_valid <= 1'b0;
            if_id_instr <= '0;
            if_id_pc    <= '0;
        end else if (pc_src) begin
            if_id_valid <= 1'b0;
        end else if (ifid_load) begin
            if_id_valid <= 1'b1;
            if_id_instr <= skid_valid ? skid_instr : imem_rdata;
            if_id_pc    <= skid_valid ? skid_pc : imem_addr;
        end else if (!stall) begin
            if_id_valid <= 1'b0;
        end
    end

    fetch_skid_buf u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (skid_load),
        .unload     (skid_unload),
        .clear      (pc_src),
        .load_instr (imem_rdata),
        .load_pc    (imem_addr),
        .valid      (skid_valid),
        .instr      (skid_instr),
        .pc         (skid_pc)
    );

    assign opcode = if_id_valid ? opcode_of(if_id_instr) : OP_NOP;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stalls  <= '0;
        end else begin
            if (ifid_load && perf_fetched != 32'hFFFF_FFFF)
                perf_fetched <= perf_fetched + 32'd1;
            if (stall && if_id_valid && perf_stalls != 32'hFFFF_FFFF)
                perf_stalls <= perf_stalls + 32'd1;
        end
    end
`else
    assign perf_fetched = '0;
    assign perf_stalls  = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a memory model answers requests, expected words are
// queued on each accepted handshake and popped when IF/ID loads.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        pc_src = 1'b0;
    logic [31:0] branch_target = '0;
    logic        imem_ready = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr, imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_instr, if_id_pc;
    logic [5:0]  opcode;
    logic [31:0] perf_fetched, perf_stalls;

    logic        w_req, w_valid;
    logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_pf, w_ps;
    logic [5:0]  w_opcode;

    int total = 0;
    int bad = 0;
    int deliveries = 0;
    int expFetched = 0;
    int expStalls = 0;
    logic [31:0] expAddr = '0;
    logic        dropPending = 1'b0;
    logic [63:0] sbQ[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[7:2] ^ 6'h15, a[27:2]};
    endfunction

    assign imem_rdata = memWord(imem_addr);
    assign w_rdata    = memWord(w_addr);

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .pc_src(pc_src), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .opcode(opcode),
        .perf_fetched(perf_fetched), .perf_stalls(perf_stalls)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .stall(1'b0), .pc_src(1'b0), .branch_target(32'h0),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ready(1'b1), .imem_rdata(w_rdata),
        .if_id_valid(w_valid), .if_id_instr(w_instr), .if_id_pc(w_pc), .opcode(w_opcode),
        .perf_fetched(w_pf), .perf_stalls(w_ps)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // One clock: book-keep the handshake before the edge, check IF/ID after it.
    task automatic tick();
        logic        preHold, hs;
        logic [31:0] heldPc, heldInstr;
        logic [63:0] e;
        preHold   = stall && if_id_valid && !pc_src;
        hs        = imem_req && imem_ready;
        heldPc    = if_id_pc;
        heldInstr = if_id_instr;
        if (stall && if_id_valid) expStalls++;
        if (imem_req && !dropPending) checkOutput("imem_addr", imem_addr, expAddr);
        if (hs) begin
            if (!dropPending && !pc_src) sbQ.push_back({expAddr, memWord(expAddr)});
            if (!dropPending) expAddr = expAddr + 32'd4;
            dropPending = 1'b0;
        end
        if (pc_src) begin
            sbQ.delete();
            if (imem_req && !imem_ready) dropPending = 1'b1;
            expAddr = branch_target;
        end
        @(posedge clk);
        #1;
        if (preHold) begin
            checkOutput("hold_valid", {31'd0, if_id_valid}, 32'd1);
            checkOutput("hold_pc", if_id_pc, heldPc);
            checkOutput("hold_instr", if_id_instr, heldInstr);
        end else if (if_id_valid) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpected_word_pc", if_id_pc, 32'hFFFF_FFFF);
            end else begin
                e = sbQ.pop_front();
                checkOutput("ifid_pc", if_id_pc, e[63:32]);
                checkOutput("ifid_instr", if_id_instr, e[31:0]);
                checkOutput("opcode", {26'd0, opcode}, {26'd0, e[31:26]});
            end
            expFetched++;
            deliveries++;
        end else begin
            checkOutput("bubble_opcode", {26'd0, opcode}, 32'd0);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic p, input logic [31:0] t, input logic r);
        stall         = s;
        pc_src        = p;
        branch_target = t;
        imem_ready    = r;
        tick();
    endtask

    task automatic doReset();
        rst = 1'b1;
        stall = 1'b0;
        pc_src = 1'b0;
        imem_ready = 1'b0;
        #1;
        checkOutput("rst_req", {31'd0, imem_req}, 32'd0);
        checkOutput("rst_addr", imem_addr, 32'h0);
        checkOutput("rst_valid", {31'd0, if_id_valid}, 32'd0);
        checkOutput("rst_instr", if_id_instr, 32'd0);
        checkOutput("rst_pc", if_id_pc, 32'd0);
        checkOutput("rst_opcode", {26'd0, opcode}, 32'd0);
        checkOutput("rst_perf_fetched", perf_fetched, 32'd0);
        checkOutput("rst_perf_stalls", perf_stalls, 32'd0);
        checkOutput("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);
        checkOutput("rst_wrap_state", {w_req, w_valid, w_opcode, 24'd0}, 32'd0);
        checkOutput("rst_wrap_regs", w_instr | w_pc | w_pf | w_ps, 32'd0);
        sbQ.delete();
        expAddr = 32'h0;
        dropPending = 1'b0;
        expFetched = 0;
        expStalls = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic waitDeliveries(input string tag, input int n);
        int start;
        start = deliveries;
        for (int i = 0; i < 40 && deliveries < start + n; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput(tag, {31'd0, deliveries >= start + n}, 32'd1);
    endtask

    initial begin
        int startDeliv;
        int stallBase;
        doReset();

        // Reset release and streaming from RESET_PC; the wrap instance runs alongside.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("first_req", {31'd0, imem_req}, 32'd1);
        checkOutput("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("wrap_next_addr", w_addr, 32'h0000_0000);
        checkOutput("first_word_pc", if_id_pc, 32'h0);
        waitDeliveries("stream_deliveries", 3);

        // Decode stall for three cycles while memory keeps answering.
        stallBase = expStalls;
        startDeliv = deliveries;
        repeat (3) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("stall_req_drop", {31'd0, imem_req}, 32'd0);
        checkOutput("stall_model_count", expStalls - stallBase, 32'd3);
`ifdef FETCH_PERF_EN
        checkOutput("perf_stalls", perf_stalls, expStalls);
`else
        checkOutput("perf_stalls_off", perf_stalls, 32'd0);
`endif
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("skid_delivered", {31'd0, if_id_valid}, 32'd1);
        waitDeliveries("post_stall_deliveries", 3);

        // Redirect with the request outstanding: late data must be discarded.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h100, 1'b0);
        checkOutput("redir_valid", {31'd0, if_id_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("redir_drop_valid", {31'd0, if_id_valid}, 32'd0);
        checkOutput("redir_addr", imem_addr, 32'h100);
        waitDeliveries("redir_deliveries", 2);

        // Second redirect while discarding overrides the first target.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h300, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h400, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("redir2_addr", imem_addr, 32'h400);
        waitDeliveries("redir2_deliveries", 2);

        // Redirect beats stall, with a word returning in the same cycle.
        applyStimulus(1'b1, 1'b1, 32'h200, 1'b1);
        checkOutput("stall_redir_valid", {31'd0, if_id_valid}, 32'd0);
        checkOutput("stall_redir_addr", imem_addr, 32'h200);
        waitDeliveries("stall_redir_deliveries", 2);

`ifdef FETCH_PERF_EN
        checkOutput("perf_fetched", perf_fetched, expFetched);
`else
        checkOutput("perf_fetched_off", perf_fetched, 32'd0);
`endif

        // Reset in the middle of an outstanding request.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        doReset();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("post_rst_req", {31'd0, imem_req}, 32'd1);
        checkOutput("post_rst_addr", imem_addr, 32'h0);
        waitDeliveries("post_rst_deliveries", 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
